// File: rtl/ccip_mmio_csr_bank_pkg.sv
//------------------------------------------------------------------------------
// Module  : ccip_mmio_csr_bank_pkg
// Brief   : CCI-P MMIO types and CSR-bank definitions shared by the CSR bank.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ccip_mmio_csr_bank_pkg;

  localparam int CCIP_CSR_WIDTH      = 64;
  localparam int CCIP_C0RX_HDR_WIDTH = 28;

  typedef logic [15:0]  t_ccip_mmioAddr;
  typedef logic [8:0]   t_ccip_tid;
  typedef logic [511:0] t_ccip_clData;
  typedef logic [63:0]  t_ccip_mmioData;

  typedef enum logic [1:0] {
    eMMIO_LEN_4B  = 2'b00,
    eMMIO_LEN_8B  = 2'b01,
    eMMIO_LEN_64B = 2'b10
  } t_ccip_mmioLen;

  typedef struct packed {
    t_ccip_mmioAddr address;
    t_ccip_mmioLen  length;
    logic           rsvd;
    t_ccip_tid      tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    logic [CCIP_C0RX_HDR_WIDTH-1:0] hdr;
    t_ccip_clData                   data;
    logic                           rspValid;
    logic                           mmioRdValid;
    logic                           mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    t_ccip_mmioData      data;
  } t_if_ccip_c2_Tx;

  typedef enum logic [1:0] {
    CSR_MODE_RW  = 2'b00,
    CSR_MODE_RO  = 2'b01,
    CSR_MODE_W1C = 2'b10
  } t_csr_mode;

  // Expands per-DWORD byte-half enables into a 64-bit bit mask.
  function automatic logic [CCIP_CSR_WIDTH-1:0] ccip_half_mask(input logic [1:0] be);
    return {{32{be[1]}}, {32{be[0]}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ccip_mmio_csr_cell.sv
//------------------------------------------------------------------------------
// Module  : ccip_mmio_csr_cell
// Brief   : One 64-bit CSR with RW/RO/W1C host semantics and a hw update port.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ccip_mmio_csr_cell
  import ccip_mmio_csr_bank_pkg::*;
#(
  parameter t_csr_mode MODE = CSR_MODE_RW
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_host_we,
  input  logic [1:0]                i_host_be,
  input  logic [CCIP_CSR_WIDTH-1:0] i_host_data,
  input  logic                      i_hw_we,
  input  logic [CCIP_CSR_WIDTH-1:0] i_hw_data,
  output logic [CCIP_CSR_WIDTH-1:0] o_q,
  output logic                      o_host_wr
);

  logic [CCIP_CSR_WIDTH-1:0] r_q;
  logic                      r_host_wr;
  logic [CCIP_CSR_WIDTH-1:0] w_mask;
  logic [CCIP_CSR_WIDTH-1:0] w_next;
  logic                      w_host_wr;

  always_comb begin
    w_mask    = i_host_we ? ccip_half_mask(i_host_be) : '0;
    w_next    = r_q;
    w_host_wr = 1'b0;
    case (MODE)
      CSR_MODE_RW: begin
        w_next    = (r_q & ~w_mask) | (i_host_data & w_mask);
        if (i_hw_we) w_next = i_hw_data;
        w_host_wr = i_host_we;
      end
      // Hardware set is applied after the host clear, so a set wins on a shared bit.
      CSR_MODE_W1C: begin
        w_next    = (r_q & ~(i_host_data & w_mask)) | (i_hw_we ? i_hw_data : '0);
        w_host_wr = i_host_we;
      end
      default: begin
        if (i_hw_we) w_next = i_hw_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q       <= '0;
      r_host_wr <= 1'b0;
    end else begin
      r_q       <= w_next;
      r_host_wr <= w_host_wr;
    end
  end

  assign o_q       = r_q;
  assign o_host_wr = r_host_wr;

endmodule

`default_nettype wire

// File: rtl/ccip_mmio_csr_bank.sv
//------------------------------------------------------------------------------
// Module  : ccip_mmio_csr_bank
// Brief   : CCI-P MMIO CSR bank: address/length decode and 2-cycle read path.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ccip_mmio_csr_bank
  import ccip_mmio_csr_bank_pkg::*;
#(
  parameter int                  NUM_CSRS = 16,
  parameter logic [15:0]         CSR_BASE = 16'h0000,
  parameter logic [NUM_CSRS-1:0] RO_MASK  = '0,
  parameter logic [NUM_CSRS-1:0] W1C_MASK = '0
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  t_if_ccip_c0_Rx                      c0Rx,
  output t_if_ccip_c2_Tx                      c2Tx,
  input  logic [NUM_CSRS-1:0]                 hw_wr_en,
  input  logic [NUM_CSRS*CCIP_CSR_WIDTH-1:0]  hw_wr_data,
  output logic [NUM_CSRS*CCIP_CSR_WIDTH-1:0]  csr_q,
  output logic [NUM_CSRS-1:0]                 csr_host_wr
);

  localparam int IDX_W = (NUM_CSRS > 1) ? $clog2(NUM_CSRS) : 1;

  t_ccip_c0_ReqMmioHdr       w_hdr;
  logic [15:0]               w_offset;
  logic                      w_borrow;
  logic                      w_in_range;
  logic                      w_len_ok;
  logic                      w_legal;
  logic                      w_is_8b;
  logic [IDX_W-1:0]          w_idx;
  logic [1:0]                w_be;
  logic [CCIP_CSR_WIDTH-1:0] w_wdata;
  logic [CCIP_CSR_WIDTH-1:0] w_csr [NUM_CSRS];
  logic [CCIP_CSR_WIDTH-1:0] w_rd_csr;
  logic [CCIP_CSR_WIDTH-1:0] w_rd_data;
  logic                      w_unused_ok;

  logic                      r_s1_valid;
  t_ccip_tid                 r_s1_tid;
  logic                      r_s1_legal;
  logic                      r_s1_len4;
  logic                      r_s1_half;
  logic [IDX_W-1:0]          r_s1_idx;
  t_if_ccip_c2_Tx            r_c2Tx;

  assign w_hdr = t_ccip_c0_ReqMmioHdr'(c0Rx.hdr);

  // A borrow out of the subtraction means the address lies below CSR_BASE.
  assign {w_borrow, w_offset} = {1'b0, w_hdr.address} - {1'b0, CSR_BASE};
  assign w_in_range = !w_borrow && (w_offset[15:1] < 15'(NUM_CSRS));
  assign w_is_8b    = (w_hdr.length == eMMIO_LEN_8B);

  always_comb begin
    w_len_ok = 1'b0;
    case (w_hdr.length)
      eMMIO_LEN_4B: w_len_ok = 1'b1;
      eMMIO_LEN_8B: w_len_ok = !w_offset[0];
      default:      w_len_ok = 1'b0;
    endcase
  end

  assign w_legal = w_in_range && w_len_ok;
  assign w_idx   = w_offset[IDX_W:1];
  assign w_be    = w_is_8b ? 2'b11 : (w_offset[0] ? 2'b10 : 2'b01);
  assign w_wdata = w_is_8b ? c0Rx.data[63:0] : {c0Rx.data[31:0], c0Rx.data[31:0]};

  generate
    for (genvar i = 0; i < NUM_CSRS; i++) begin : g_csr
      ccip_mmio_csr_cell #(
        .MODE (RO_MASK[i] ? CSR_MODE_RO : (W1C_MASK[i] ? CSR_MODE_W1C : CSR_MODE_RW))
      ) u_cell (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_host_we   (c0Rx.mmioWrValid && w_legal && (w_idx == IDX_W'(i))),
        .i_host_be   (w_be),
        .i_host_data (w_wdata),
        .i_hw_we     (hw_wr_en[i]),
        .i_hw_data   (hw_wr_data[CCIP_CSR_WIDTH*i +: CCIP_CSR_WIDTH]),
        .o_q         (w_csr[i]),
        .o_host_wr   (csr_host_wr[i])
      );
      assign csr_q[CCIP_CSR_WIDTH*i +: CCIP_CSR_WIDTH] = w_csr[i];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_tid   <= '0;
      r_s1_legal <= 1'b0;
      r_s1_len4  <= 1'b0;
      r_s1_half  <= 1'b0;
      r_s1_idx   <= '0;
    end else begin
      r_s1_valid <= c0Rx.mmioRdValid;
      if (c0Rx.mmioRdValid) begin
        r_s1_tid   <= w_hdr.tid;
        r_s1_legal <= w_legal;
        r_s1_len4  <= (w_hdr.length == eMMIO_LEN_4B);
        r_s1_half  <= w_offset[0];
        r_s1_idx   <= w_legal ? w_idx : '0;
      end
    end
  end

  assign w_rd_csr = w_csr[r_s1_idx];

  always_comb begin
    w_rd_data = '0;
    if (r_s1_legal) begin
      if (r_s1_len4) w_rd_data = {32'h0, (r_s1_half ? w_rd_csr[63:32] : w_rd_csr[31:0])};
      else           w_rd_data = w_rd_csr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_c2Tx <= '0;
    end else begin
      r_c2Tx.mmioRdValid <= r_s1_valid;
      if (r_s1_valid) begin
        r_c2Tx.hdr.tid <= r_s1_tid;
        r_c2Tx.data    <= w_rd_data;
      end
    end
  end

  assign c2Tx = r_c2Tx;

  assign w_unused_ok = &{1'b0, c0Rx.data[511:64], c0Rx.rspValid, w_hdr.rsvd, w_offset};

endmodule

`default_nettype wire

// File: tb/tb_ccip_mmio_csr_bank.sv
//------------------------------------------------------------------------------
// Module  : tb_ccip_mmio_csr_bank
// Brief   : Directed scoreboard bench for the CCI-P MMIO CSR bank.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ccip_mmio_csr_bank;
  import ccip_mmio_csr_bank_pkg::*;

  localparam int          N     = 16;
  localparam logic [N-1:0] RO_M  = 16'h0020;
  localparam logic [N-1:0] W1C_M = 16'h0010;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  t_if_ccip_c0_Rx    c0Rx;
  t_if_ccip_c2_Tx    c2Tx;
  logic [N-1:0]      hw_wr_en;
  logic [N*64-1:0]   hw_wr_data;
  logic [N*64-1:0]   csr_q;
  logic [N-1:0]      csr_host_wr;

  ccip_mmio_csr_bank #(
    .NUM_CSRS (N),
    .CSR_BASE (16'h0000),
    .RO_MASK  (RO_M),
    .W1C_MASK (W1C_M)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .c0Rx        (c0Rx),
    .c2Tx        (c2Tx),
    .hw_wr_en    (hw_wr_en),
    .hw_wr_data  (hw_wr_data),
    .csr_q       (csr_q),
    .csr_host_wr (csr_host_wr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          due;
  } t_exp;

  t_exp        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] m [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bank(input string name);
    int bad = -1;
    for (int i = 0; i < N; i++)
      if (bad < 0 && csr_q[64*i +: 64] !== m[i]) bad = i;
    n_cmp++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s: csr_q[%0d] got %h expected %h", name, bad, csr_q[64*bad +: 64], m[bad]);
    end
  endtask

  task automatic issue(input logic is_rd, input logic [15:0] addr, input logic [1:0] len,
                       input logic [8:0] tid, input logic [63:0] data);
    t_ccip_c0_ReqMmioHdr h;
    h.address = addr;
    h.length  = t_ccip_mmioLen'(len);
    h.rsvd    = 1'b0;
    h.tid     = tid;
    c0Rx.hdr         = h;
    c0Rx.data        = {448'h0, data};
    c0Rx.mmioRdValid = is_rd;
    c0Rx.mmioWrValid = !is_rd;
    @(negedge clk);
    c0Rx.mmioRdValid = 1'b0;
    c0Rx.mmioWrValid = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [1:0] len, input logic [63:0] data);
    issue(1'b0, addr, len, 9'h0, data);
  endtask

  task automatic rd(input logic [15:0] addr, input logic [1:0] len, input logic [8:0] tid,
                    input logic [63:0] exp, input logic push);
    if (push) sb.push_back('{tid: tid, data: exp, due: cyc + 2});
    issue(1'b1, addr, len, tid, 64'h0);
  endtask

  task automatic hw(input int idx, input logic [63:0] data);
    hw_wr_en[idx]              = 1'b1;
    hw_wr_data[64*idx +: 64]   = data;
    @(negedge clk);
    hw_wr_en = '0;
  endtask

  // Response monitor: every valid beat must match the head of the scoreboard on its due cycle.
  always @(negedge clk) begin
    t_exp e;
    if (c2Tx.mmioRdValid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: got tid %h data %h at cycle %0d, required no response",
                 c2Tx.hdr.tid, c2Tx.data, cyc);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (c2Tx.hdr.tid !== e.tid || c2Tx.data !== e.data || cyc != e.due) begin
          n_err++;
          $display("FAIL rsp: got tid %h data %h cycle %0d, required tid %h data %h cycle %0d",
                   c2Tx.hdr.tid, c2Tx.data, cyc, e.tid, e.data, e.due);
        end
      end
    end else if (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL rsp_missing: got nothing by cycle %0d, required tid %h data %h at cycle %0d",
               cyc, e.tid, e.data, e.due);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    c0Rx       = '0;
    hw_wr_en   = '0;
    hw_wr_data = '0;
    for (int i = 0; i < N; i++) m[i] = 64'h0;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdvalid", 64'(c2Tx.mmioRdValid), 64'h0);
    chk("rst_host_wr", 64'(csr_host_wr), 64'h0);
    chk_bank("rst_bank");
    reset_n = 1'b1;
    @(negedge clk);

    // 8B write then back-to-back 8B read of CSR 3
    wr(16'd6, 2'b01, 64'hDEADBEEF_01234567);
    m[3] = 64'hDEADBEEF_01234567;
    chk("t1_host_wr", 64'(csr_host_wr), 64'h0008);
    chk_bank("t1_bank");
    rd(16'd6, 2'b01, 9'h1A5, m[3], 1'b1);

    // 4B write to the high half, then 4B and 8B reads
    wr(16'd7, 2'b00, 64'h0000_0000_CAFEF00D);
    m[3] = 64'hCAFEF00D_01234567;
    chk("t2_host_wr", 64'(csr_host_wr), 64'h0008);
    rd(16'd7, 2'b00, 9'h002, 64'h00000000_CAFEF00D, 1'b1);
    rd(16'd6, 2'b01, 9'h003, m[3], 1'b1);

    // Illegal reads answer zero, illegal writes change nothing
    rd(16'd32, 2'b01, 9'h004, 64'h0, 1'b1);
    rd(16'd5,  2'b01, 9'h005, 64'h0, 1'b1);
    rd(16'd6,  2'b10, 9'h006, 64'h0, 1'b1);
    wr(16'd32, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3_oor_host_wr", 64'(csr_host_wr), 64'h0);
    wr(16'd5, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3_mis_host_wr", 64'(csr_host_wr), 64'h0);
    wr(16'd6, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3_len_host_wr", 64'(csr_host_wr), 64'h0);
    chk_bank("t3_bank");

    // W1C CSR 4: sticky set, then simultaneous clear and set
    hw(4, 64'hFF);
    m[4] = 64'hFF;
    chk_bank("t4_w1c_set");
    hw_wr_en[4]          = 1'b1;
    hw_wr_data[64*4 +: 64] = 64'h01;
    wr(16'd8, 2'b01, 64'h0F);
    hw_wr_en = '0;
    m[4] = 64'hF1;
    chk("t4_w1c_host_wr", 64'(csr_host_wr), 64'h0010);
    chk_bank("t4_w1c_bank");

    // RO CSR 5 ignores host writes but loads hw data
    wr(16'd10, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t4_ro_host_wr", 64'(csr_host_wr), 64'h0);
    wr(16'd11, 2'b00, 64'hFFFF_FFFF);
    chk_bank("t4_ro_bank");
    hw(5, 64'h1234);
    m[5] = 64'h1234;
    chk_bank("t4_ro_hw");

    // RW CSR 6: hw wins over a simultaneous host write
    hw_wr_en[6]          = 1'b1;
    hw_wr_data[64*6 +: 64] = 64'h2222;
    wr(16'd12, 2'b01, 64'h1111);
    hw_wr_en = '0;
    m[6] = 64'h2222;
    chk("t4_rw_host_wr", 64'(csr_host_wr), 64'h0040);
    chk_bank("t4_rw_bank");

    // 4B write to the high half of CSR 0
    wr(16'd1, 2'b00, 64'h0000_ABCD);
    m[0] = 64'h0000ABCD_00000000;
    chk_bank("t4_hi_half");

    // Eight pipelined reads, tids 0..7
    for (int k = 0; k < 8; k++) rd(16'(2*k), 2'b01, 9'(k), m[k], 1'b1);

    // hw update in the cycle after a read is not visible to that read
    rd(16'd14, 2'b01, 9'h008, 64'h0, 1'b1);
    hw(7, 64'h77);
    m[7] = 64'h77;
    chk_bank("t5_hw_late");
    repeat (4) @(negedge clk);

    // Reset while two reads are in flight: no responses, bank cleared
    rd(16'd6, 2'b01, 9'h00A, 64'h0, 1'b0);
    reset_n = 1'b0;
    rd(16'd6, 2'b01, 9'h00B, 64'h0, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) m[i] = 64'h0;
    repeat (3) @(negedge clk);
    chk_bank("t6_bank");
    chk("t6_host_wr", 64'(csr_host_wr), 64'h0);
    rd(16'd6, 2'b01, 9'h00C, 64'h0, 1'b1);
    repeat (5) @(negedge clk);

    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
